// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and IF/ID outputs.
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;

  modport master (
    output imem_addr, pc, if_id_inst, if_id_pc_plus4, if_id_valid, fetch_fault,
    input  imem_inst, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, pc, if_id_inst, if_id_pc_plus4, if_id_valid, fetch_fault,
    output imem_inst, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, loads IF/ID, sequences boot hold,
// stall/flush/redirect, and latches a sticky fault on illegal fetch addresses.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          BOOT_HOLD  = 4,
  parameter int          IMEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset,
  imem_fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t       BUBBLE   = '0;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [31:0] pc_q;
  logic [31:0] pend_pc;
  logic        pend_vld;
  logic        fault_q;
  ifid_t       ifid;

  logic [31:0] pc_plus4;
  logic        pc_bad;
  logic [31:0] redir_tgt;

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);
  assign redir_tgt = bus.redirect_valid ? bus.redirect_pc : pend_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      hold_cnt <= 8'(BOOT_HOLD);
      pc_q     <= RESET_PC;
      pend_pc  <= '0;
      pend_vld <= 1'b0;
      fault_q  <= 1'b0;
      ifid     <= BUBBLE;
    end else begin
      case (state)
        BOOT: begin
          ifid <= BUBBLE;
          if (bus.redirect_valid) begin
            pend_pc  <= bus.redirect_pc;
            pend_vld <= 1'b1;
          end
          // The hold spans BOOT_HOLD+1 edges so the first fetch lands after edge BOOT_HOLD+1.
          if (hold_cnt == 8'd0) state <= RUN;
          else                  hold_cnt <= hold_cnt - 8'd1;
        end
        RUN: begin
          if (pc_bad) begin
            ifid    <= BUBBLE;
            fault_q <= 1'b1;
            state   <= FAULT;
          end else if (bus.stall) begin
            if (bus.flush) ifid <= BUBBLE;
            if (bus.redirect_valid) begin
              pend_pc  <= bus.redirect_pc;
              pend_vld <= 1'b1;
            end
          end else if (bus.redirect_valid || pend_vld) begin
            pc_q     <= redir_tgt;
            ifid     <= BUBBLE;
            pend_vld <= 1'b0;
          end else if (bus.flush) begin
            ifid <= BUBBLE;
            pc_q <= pc_plus4;
          end else begin
            ifid <= '{inst: bus.imem_inst, pc_plus4: pc_plus4, valid: 1'b1};
            pc_q <= pc_plus4;
          end
        end
        FAULT: ifid <= BUBBLE;
        default: state <= FAULT;
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.imem_addr      = pc_q;
  assign bus.if_id_inst     = ifid.inst;
  assign bus.if_id_pc_plus4 = ifid.pc_plus4;
  assign bus.if_id_valid    = ifid.valid;
  assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: boot hold, sequential fetch, redirect,
// stall/flush, pending redirect, faults and async reset.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [256];

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(.RESET_PC(32'h0), .BOOT_HOLD(4), .IMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_inst = (bus.imem_addr < 32'd1024) ? mem[bus.imem_addr[9:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pcp4,
                          input logic vld);
    chk({tag, ".inst"}, bus.if_id_inst, inst);
    chk({tag, ".pcp4"}, bus.if_id_pc_plus4, pcp4);
    chk({tag, ".vld"}, 32'(bus.if_id_valid), 32'(vld));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"}, bus.pc, 32'h0);
    chk({tag, ".addr"}, bus.imem_addr, 32'h0);
    chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'h0);
    chk_ifid(tag, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h2010_0000;
    mem[1] = 32'h8e11_0000;

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #12;
    chk_reset_state("rst");
    @(negedge clk) reset = 1'b0;

    // Boot hold: edges 0..4 produce only bubbles at RESET_PC
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("boot.vld", 32'(bus.if_id_valid), 32'h0);
      chk("boot.pc", bus.pc, 32'h0);
    end

    step(1);
    chk_ifid("fetch0", 32'h2010_0000, 32'h4, 1'b1);
    chk("fetch0.pc", bus.pc, 32'h4);
    step(1);
    chk_ifid("fetch1", 32'h8e11_0000, 32'h8, 1'b1);
    chk("fetch1.pc", bus.pc, 32'h8);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h24;
    step(1);
    chk("redir.pc", bus.pc, 32'h24);
    chk("redir.vld", 32'(bus.if_id_valid), 32'h0);
    bus.redirect_valid = 1'b0;
    step(1);
    chk_ifid("redir_tgt", 32'h1000_0009, 32'h28, 1'b1);
    chk("redir_tgt.pc", bus.pc, 32'h28);

    // Three stalled cycles with a redirect pulse in the second
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall.pc", bus.pc, 32'h28);
      chk_ifid("stall", 32'h1000_0009, 32'h28, 1'b1);
      bus.redirect_valid = (i == 0);
      bus.redirect_pc = (i == 0) ? 32'h40 : 32'h0;
    end
    bus.stall = 1'b0;
    step(1);
    chk("pend.pc", bus.pc, 32'h40);
    chk("pend.vld", 32'(bus.if_id_valid), 32'h0);
    step(1);
    chk_ifid("pend_tgt", 32'h1000_0010, 32'h44, 1'b1);
    chk("pend_tgt.pc", bus.pc, 32'h44);
    step(1);
    chk_ifid("seq", 32'h1000_0011, 32'h48, 1'b1);

    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step(1);
    chk("stfl.pc", bus.pc, 32'h48);
    chk_ifid("stfl", 32'h0, 32'h0, 1'b0);
    bus.stall = 1'b0;
    step(1);
    chk("flush.pc", bus.pc, 32'h4c);
    chk("flush.vld", 32'(bus.if_id_valid), 32'h0);
    bus.flush = 1'b0;
    step(1);
    chk_ifid("post_flush", 32'h1000_0013, 32'h50, 1'b1);
    chk("post_flush.pc", bus.pc, 32'h50);

    // Misaligned redirect target faults on the next cycle
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h402;
    step(1);
    chk("mis.pc", bus.pc, 32'h402);
    bus.redirect_pc = 32'h0;
    bus.redirect_valid = 1'b0;
    step(1);
    chk("mis.fault", 32'(bus.fetch_fault), 32'h1);
    chk("mis.pc2", bus.pc, 32'h402);
    chk_ifid("mis", 32'h0, 32'h0, 1'b0);
    bus.redirect_valid = 1'b1;
    step(1);
    chk("fault_hold.pc", bus.pc, 32'h402);
    chk("fault_hold.fault", 32'(bus.fetch_fault), 32'h1);
    bus.redirect_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset_state("rst2");
    @(negedge clk) reset = 1'b0;

    // Redirect captured during boot, then sequential run into the range limit
    step(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3fc;
    step(1);
    bus.redirect_valid = 1'b0;
    step(3);
    chk("boot_pend.pc", bus.pc, 32'h0);
    chk("boot_pend.vld", 32'(bus.if_id_valid), 32'h0);
    step(1);
    chk("boot_pend.tgt", bus.pc, 32'h3fc);
    step(1);
    chk_ifid("last_word", 32'h1000_00ff, 32'h400, 1'b1);
    chk("last_word.pc", bus.pc, 32'h400);
    step(1);
    chk("range.fault", 32'(bus.fetch_fault), 32'h1);
    chk("range.pc", bus.pc, 32'h400);
    chk("range.vld", 32'(bus.if_id_valid), 32'h0);

    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
    step(7);
    chk("run.pc", bus.pc, 32'h8);
    chk("run.vld", 32'(bus.if_id_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk_reset_state("async");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
